// File: rtl/mux_nx1_scan.sv
// N:1, W-bit registered multiplexer with a valid/ready output slot, manual or round-robin scan select.
// Optional channel masking is compiled in with `define MUX_CHMASK_EN.
module mux_nx1_scan #(
  parameter int N    = 5,
  parameter int W    = 1,
  // Derived from N; overriding it breaks the pointer arithmetic.
  parameter int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*W-1:0]    i,
  input  logic [SELW-1:0]   s,
  input  logic              mode,
`ifdef MUX_CHMASK_EN
  input  logic [N-1:0]      ch_mask,
`endif
  input  logic              en,
  input  logic              y_ready,
  output logic [W-1:0]      y,
  output logic              y_valid,
  output logic [SELW-1:0]   ch,
  output logic              sel_err
);

  localparam logic [SELW:0] NMAX = (SELW+1)'(N);

  logic [W-1:0]    chan [N];
  logic [N-1:0]    ch_en;

  logic [W-1:0]    y_q, y_d;
  logic            y_valid_q, y_valid_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic            sel_err_q, sel_err_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic            slot_free;
  logic            manual_legal;
  logic            scan_found;
  logic [SELW-1:0] scan_sel;
  logic [SELW:0]   cand_sum;
  logic [SELW-1:0] cand;
  logic [SELW-1:0] sel;
  logic            legal;
  logic            capture;

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan[k] = i[k*W +: W];
  end

`ifdef MUX_CHMASK_EN
  assign ch_en = ch_mask;
`else
  assign ch_en = '1;
`endif

  // Scan search: first enabled channel at or after ptr, wrapping past N-1.
  always_comb begin
    scan_found = 1'b0;
    scan_sel   = ptr_q;
    cand_sum   = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand_sum = {1'b0, ptr_q} + (SELW+1)'(k);
      if (cand_sum >= NMAX) cand_sum = cand_sum - NMAX;
      cand = cand_sum[SELW-1:0];
      if (!scan_found && ch_en[cand]) begin
        scan_found = 1'b1;
        scan_sel   = cand;
      end
    end
  end

  always_comb begin
    y_d          = y_q;
    y_valid_d    = y_valid_q;
    ch_d         = ch_q;
    sel_err_d    = sel_err_q;
    ptr_d        = ptr_q;

    slot_free    = !y_valid_q || y_ready;
    manual_legal = ({1'b0, s} < NMAX) && ch_en[s];
    sel          = mode ? scan_sel : s;
    legal        = mode ? 1'b1 : manual_legal;
    capture      = en && slot_free && (mode ? scan_found : 1'b1);

    if (capture) begin
      y_d       = legal ? chan[sel] : '0;
      ch_d      = sel;
      sel_err_d = !legal;
      y_valid_d = 1'b1;
      if (mode) begin
        ptr_d = ({1'b0, scan_sel} == NMAX - 1'b1) ? '0 : scan_sel + 1'b1;
      end
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ch_q      <= '0;
      sel_err_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ch_q      <= ch_d;
      sel_err_q <= sel_err_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign ch      = ch_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Table-driven bench for mux_nx1_scan: a W=8 and a W=1 instance share all controls.
// The masked-channel sequence is compiled only with `define MUX_CHMASK_EN.
module tb_mux_nx1_scan;

  localparam logic [39:0] I8 = 40'h54_43_32_21_10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] s;
  logic       mode;
  logic       en;
  logic       y_ready;
  logic [4:0] i1;
  logic [39:0] i8;

  logic [7:0] y8;
  logic       valid8;
  logic [2:0] ch8;
  logic       err8;
  logic [0:0] y1;
  logic       valid1;
  logic [2:0] ch1;
  logic       err1;

`ifdef MUX_CHMASK_EN
  logic [4:0] ch_mask;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic       rst_n;
    logic       mode;
    logic       en;
    logic       rdy;
    logic [2:0] s;
    logic [4:0] i1;
    logic       ev;
    logic [7:0] ey;
    logic       ey1;
    logic [2:0] ech;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mux_nx1_scan #(.N(5), .W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i(i8), .s(s), .mode(mode),
`ifdef MUX_CHMASK_EN
    .ch_mask(ch_mask),
`endif
    .en(en), .y_ready(y_ready), .y(y8), .y_valid(valid8), .ch(ch8), .sel_err(err8)
  );

  mux_nx1_scan #(.N(5), .W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i(i1), .s(s), .mode(mode),
`ifdef MUX_CHMASK_EN
    .ch_mask(ch_mask),
`endif
    .en(en), .y_ready(y_ready), .y(y1), .y_valid(valid1), .ch(ch1), .sel_err(err1)
  );

  function automatic vec_t mk(logic r, logic m, logic e, logic rd, logic [2:0] sv,
                              logic [4:0] iv, logic ev, logic [7:0] ey, logic ey1,
                              logic [2:0] ech, logic eerr);
    vec_t v;
    v.rst_n = r;  v.mode = m;  v.en = e;   v.rdy = rd;  v.s = sv;  v.i1 = iv;
    v.ev = ev;    v.ey = ey;   v.ey1 = ey1; v.ech = ech; v.eerr = eerr;
    return v;
  endfunction

  task automatic applyStimulus(vec_t v);
    rst_n   = v.rst_n;
    mode    = v.mode;
    en      = v.en;
    y_ready = v.rdy;
    s       = v.s;
    i1      = v.i1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic runVec(string tag, vec_t v);
    applyStimulus(v);
    checkOutput({tag, " y_valid"}, 32'(valid8), 32'(v.ev));
    checkOutput({tag, " y"},       32'(y8),     32'(v.ey));
    checkOutput({tag, " ch"},      32'(ch8),    32'(v.ech));
    checkOutput({tag, " sel_err"}, 32'(err8),   32'(v.eerr));
    checkOutput({tag, " y_valid(W1)"}, 32'(valid1), 32'(v.ev));
    checkOutput({tag, " y(W1)"},   32'(y1),     32'(v.ey1));
    checkOutput({tag, " ch(W1)"},  32'(ch1),    32'(v.ech));
  endtask

  initial begin
    i8      = I8;
    rst_n   = 1'b0;
    mode    = 1'b0;
    en      = 1'b0;
    y_ready = 1'b0;
    s       = '0;
    i1      = '0;
`ifdef MUX_CHMASK_EN
    ch_mask = 5'b11111;
`endif

    //                 rst m  en rdy s  i1        valid y      y1 ch err
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'b00000,  0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 5'b00000,  0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 3, 5'b01000,  1, 8'h43, 1, 3, 0));
    vecs.push_back(mk(1, 0, 1, 1, 6, 5'b01000,  1, 8'h00, 0, 6, 1));
    vecs.push_back(mk(1, 0, 1, 1, 1, 5'b00010,  1, 8'h21, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 7, 5'b00010,  1, 8'h00, 0, 7, 1));
    vecs.push_back(mk(1, 0, 1, 1, 4, 5'b10000,  1, 8'h54, 1, 4, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4, 5'b10000,  0, 8'h54, 1, 4, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4, 5'b10000,  0, 8'h54, 1, 4, 0));
    // Scan walk with wrap, one capture per cycle
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h10, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h21, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h32, 1, 2, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h43, 0, 3, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h54, 1, 4, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h10, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h21, 0, 1, 0));
    // Back-pressure: 8'h32 held, then handoff and capture on one edge
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h32, 1, 2, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'b00000,  1, 8'h32, 1, 2, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'b00000,  1, 8'h32, 1, 2, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'b00000,  1, 8'h32, 1, 2, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h43, 0, 3, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h54, 1, 4, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h10, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h21, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h32, 1, 2, 0));
    // ptr is 3: two manual captures, then scan resumes at 3
    vecs.push_back(mk(1, 0, 1, 1, 1, 5'b10101,  1, 8'h21, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 6, 5'b10101,  1, 8'h00, 0, 6, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h43, 0, 3, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'b10101,  1, 8'h43, 0, 3, 0));
    // Reset while a sample is pending, then scan restarts at channel 0
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'b10101,  0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'b10101,  1, 8'h10, 1, 0, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      runVec($sformatf("vec%0d", k), vecs[k]);
    end

    runVec("err_then_reset a", mk(1, 0, 1, 1, 5, 5'b10101, 1, 8'h00, 0, 5, 1));
    runVec("err_then_reset b", mk(0, 0, 1, 1, 5, 5'b10101, 0, 8'h00, 0, 0, 0));
    runVec("empty_slot_rdy0",  mk(1, 0, 1, 0, 2, 5'b10101, 1, 8'h32, 1, 2, 0));
    runVec("hold_en_ignored",  mk(1, 0, 1, 0, 0, 5'b10101, 1, 8'h32, 1, 2, 0));

`ifdef MUX_CHMASK_EN
    ch_mask = 5'b10101;
    runVec("mask scan 0", mk(1, 1, 1, 1, 0, 5'b10101, 1, 8'h10, 1, 0, 0));
    runVec("mask scan 2", mk(1, 1, 1, 1, 0, 5'b10101, 1, 8'h32, 1, 2, 0));
    runVec("mask scan 4", mk(1, 1, 1, 1, 0, 5'b10101, 1, 8'h54, 1, 4, 0));
    runVec("mask scan 0b", mk(1, 1, 1, 1, 0, 5'b10101, 1, 8'h10, 1, 0, 0));
    runVec("mask drain",  mk(1, 1, 0, 1, 0, 5'b10101, 0, 8'h10, 1, 0, 0));
    ch_mask = 5'b00000;
    runVec("mask none a", mk(1, 1, 1, 1, 0, 5'b10101, 0, 8'h10, 1, 0, 0));
    runVec("mask none b", mk(1, 1, 1, 1, 0, 5'b10101, 0, 8'h10, 1, 0, 0));
    ch_mask = 5'b10101;
    runVec("mask manual off", mk(1, 0, 1, 1, 1, 5'b10101, 1, 8'h00, 0, 1, 1));
    runVec("mask manual on",  mk(1, 0, 1, 1, 2, 5'b10101, 1, 8'h32, 1, 2, 0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
